pwm_gen: RTL and testbench

//  Multi-channel programmable waveform generator, synthesisable successor to the bench clk_gen/rst_n_gen models.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_chan.sv | 126 ++++++++++++
 rtl/pwm_gen.sv | 44 ++++
 tb/tb_pwm_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, config layout and default widths for pwm_gen
package pwm_pkg;
  localparam int PWM_CW = 32;
  localparam int PWM_RW = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RUN} pwm_st_e;
  typedef struct packed {
    logic [PWM_CW-1:0] period;
    logic [PWM_CW-1:0] high;
    logic [PWM_CW-1:0] delay;
    logic [PWM_RW-1:0] reps;
  } pwm_cfg_t;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one waveform channel with FSM, counters and double-buffered config
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CW = PWM_CW,
  parameter int RW = PWM_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [CW-1:0] period_i,
  input  logic [CW-1:0] high_i,
  input  logic [CW-1:0] delay_i,
  input  logic [RW-1:0] reps_i,
  input  logic          start_i,
  input  logic          stop_i,
  output logic          out_o,
  output logic          tick_o,
  output logic          done_o,
  output logic          busy_o,
  output logic          pend_o
);
  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic [CW-1:0] delay;
    logic [RW-1:0] reps;
  } cfg_t;
  pwm_st_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, dly_q, dly_d;
  logic [RW-1:0] rep_q, rep_d;
  cfg_t sh_q, sh_d, act_q, act_d, cfg_in, nxt;
  logic pend_q, pend_d, out_q, out_d, tick_q, tick_d, done_q, done_d, wrap;
  assign cfg_in = {period_i, high_i, delay_i, reps_i};
  assign wrap = st_q == ST_RUN && act_q.period != '0 && cnt_q == act_q.period - CW'(1);
  assign nxt = pend_q ? sh_q : act_q;
  assign out_o = out_q;
  assign tick_o = tick_q;
  assign done_o = done_q;
  assign busy_o = st_q != ST_IDLE;
  assign pend_o = pend_q;
  // State and output registers; everything clears on reset, including both config copies
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      dly_q  <= '0;
      rep_q  <= '0;
      sh_q   <= '0;
      act_q  <= '0;
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dly_q  <= dly_d;
      rep_q  <= rep_d;
      sh_q   <= sh_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end
  // Next-state logic; outputs are computed for the state being entered so they register in step with it
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    dly_d  = dly_q;
    rep_d  = rep_q;
    sh_d   = wr_i ? cfg_in : sh_q;
    act_d  = act_q;
    out_d  = 1'b0;
    tick_d = 1'b0;
    done_d = 1'b0;
    case (st_q)
      ST_IDLE: begin
        act_d = sh_q;
        if (start_i && !stop_i) begin
          cnt_d  = '0;
          rep_d  = '0;
          dly_d  = sh_q.delay - CW'(1);
          st_d   = sh_q.delay != '0 ? ST_DELAY : ST_RUN;
          tick_d = sh_q.delay == '0 && sh_q.period != '0;
          out_d  = tick_d && sh_q.high != '0;
        end
      end
      ST_DELAY: begin
        dly_d  = dly_q - CW'(1);
        st_d   = dly_q == '0 ? ST_RUN : ST_DELAY;
        tick_d = dly_q == '0 && act_q.period != '0;
        out_d  = tick_d && act_q.high != '0;
      end
      ST_RUN: begin
        if (wrap && act_q.reps != '0 && rep_q + RW'(1) == act_q.reps) begin
          st_d   = ST_IDLE;
          cnt_d  = '0;
          rep_d  = '0;
          done_d = 1'b1;
        end else if (wrap) begin
          cnt_d  = '0;
          rep_d  = act_q.reps != '0 ? rep_q + RW'(1) : rep_q;
          act_d  = nxt;
          tick_d = nxt.period != '0;
          out_d  = tick_d && nxt.high != '0;
        end else if (act_q.period != '0) begin
          cnt_d = cnt_q + CW'(1);
          out_d = cnt_q + CW'(1) < act_q.high;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (stop_i && st_q != ST_IDLE) begin
      st_d   = ST_IDLE;
      cnt_d  = '0;
      rep_d  = '0;
      out_d  = 1'b0;
      tick_d = 1'b0;
      done_d = 1'b0;
    end
    pend_d = st_d == ST_IDLE ? 1'b0 : wr_i ? 1'b1 : wrap ? 1'b0 : pend_q;
  end
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: multi-channel programmable waveform generator with shared config bus
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW = PWM_CW,
  parameter int RW = PWM_RW,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic [CW-1:0]  cfg_delay,
  input  logic [RW-1:0]  cfg_reps,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] cfg_pend
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_chan #(.CW(CW), .RW(RW)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (cfg_wr && cfg_ch == CHW'(i)),
      .period_i(cfg_period),
      .high_i  (cfg_high),
      .delay_i (cfg_delay),
      .reps_i  (cfg_reps),
      .start_i (start[i]),
      .stop_i  (stop[i]),
      .out_o   (out[i]),
      .tick_o  (tick[i]),
      .done_o  (done[i]),
      .busy_o  (busy[i]),
      .pend_o  (cfg_pend[i])
    );
  end
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: scoreboard-driven bench for pwm_gen
module tb_pwm_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [31:0] cfg_period = '0, cfg_high = '0, cfg_delay = '0;
  logic [15:0] cfg_reps = '0;
  logic [3:0] start = '0, stop = '0;
  logic [3:0] out, tick, done, busy, cfg_pend;
  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];
  pwm_gen #(.NCH(4), .CW(32), .RW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_delay(cfg_delay), .cfg_reps(cfg_reps),
    .start(start), .stop(stop), .out(out), .tick(tick), .done(done), .busy(busy), .cfg_pend(cfg_pend)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] chan(input int c);
    return {out[c], tick[c], busy[c], done[c], cfg_pend[c]};
  endfunction
  task automatic wr(input int c, input logic [31:0] p, input logic [31:0] h, input logic [31:0] d, input logic [15:0] r);
    cfg_ch = 2'(c);
    cfg_period = p;
    cfg_high = h;
    cfg_delay = d;
    cfg_reps = r;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (out !== 4'b0) begin errors++; $display("FAIL reset_out: got %b want 0000", out); end
    checks++; if (tick !== 4'b0) begin errors++; $display("FAIL reset_tick: got %b want 0000", tick); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (busy !== 4'b0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
    checks++; if (cfg_pend !== 4'b0) begin errors++; $display("FAIL reset_pend: got %b want 0000", cfg_pend); end
    rst_n = 1'b1;
  endtask
  task automatic test_basic;
    logic [4:0] e;
    wr(0, 10, 3, 0, 0);
    start = 4'b0001;
    for (int k = 1; k <= 30; k++) sb.push_back({(k - 1) % 10 < 3, (k - 1) % 10 == 0, 1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); start = '0;
      e = sb.pop_front(); checks++;
      if (chan(0) !== e) begin errors++; $display("FAIL basic[%0d]: got %b want %b (out,tick,busy,done,pend)", k, chan(0), e); end
    end
  endtask
  task automatic test_cfg_update;
    logic [4:0] e;
    for (int ph = 0; ph < 4; ph++) sb.push_back({ph < 3, ph == 0, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (chan(0) !== e) begin errors++; $display("FAIL cfg_pre[%0d]: got %b want %b", k, chan(0), e); end
    end
    cfg_ch = 2'd0; cfg_period = 6; cfg_high = 1; cfg_delay = 0; cfg_reps = 0; cfg_wr = 1'b1;
    for (int ph = 4; ph < 10; ph++) sb.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    for (int j = 0; j < 12; j++) sb.push_back({j % 6 < 1, j % 6 == 0, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); cfg_wr = 1'b0;
      e = sb.pop_front(); checks++;
      if (chan(0) !== e) begin errors++; $display("FAIL cfg_upd[%0d]: got %b want %b", k, chan(0), e); end
    end
  endtask
  task automatic test_delay_reps;
    logic [4:0] e;
    logic run;
    wr(1, 4, 2, 5, 3);
    start = 4'b0010;
    for (int k = 1; k <= 22; k++) begin
      run = k >= 6 && k <= 17;
      sb.push_back({run && (k - 6) % 4 < 2, run && (k - 6) % 4 == 0, k <= 17, k == 18, 1'b0});
    end
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk); start = '0;
      e = sb.pop_front(); checks++;
      if (chan(1) !== e) begin errors++; $display("FAIL delay_reps[t+%0d]: got %b want %b", k, chan(1), e); end
    end
  endtask
  task automatic test_start_stop;
    logic [4:0] e;
    wr(2, 5, 2, 0, 0);
    start = 4'b0100; stop = 4'b0100;
    repeat (3) sb.push_back(5'b0);
    for (int k = 1; k <= 4; k++) sb.push_back({k - 1 < 2, k == 1, 1'b1, 1'b0, 1'b0});
    repeat (4) sb.push_back(5'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); start = '0; stop = '0;
      if (k == 3) start = 4'b0100;
      if (k == 7) stop = 4'b0100;
      e = sb.pop_front(); checks++;
      if (chan(2) !== e) begin errors++; $display("FAIL start_stop[%0d]: got %b want %b", k, chan(2), e); end
    end
  endtask
  task automatic test_edges;
    logic [4:0] e;
    wr(3, 1, 1, 0, 0);
    start = 4'b1000;
    repeat (5) sb.push_back(5'b11100);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); start = '0;
      e = sb.pop_front(); checks++;
      if (chan(3) !== e) begin errors++; $display("FAIL period1[%0d]: got %b want %b", k, chan(3), e); end
    end
    stop = 4'b1000;
    @(negedge clk); stop = '0;
    wr(3, 10, 12, 0, 0);
    start = 4'b1000;
    for (int k = 1; k <= 12; k++) sb.push_back({1'b1, (k - 1) % 10 == 0, 1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); start = '0;
      e = sb.pop_front(); checks++;
      if (chan(3) !== e) begin errors++; $display("FAIL high_ge_period[%0d]: got %b want %b", k, chan(3), e); end
    end
    stop = 4'b1000;
    @(negedge clk); stop = '0;
    checks++; if (chan(3) !== 5'b0) begin errors++; $display("FAIL edge_stop: got %b want 00000", chan(3)); end
    wr(3, 0, 0, 0, 0);
    start = 4'b1000;
    repeat (5) sb.push_back(5'b00100);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); start = '0;
      e = sb.pop_front(); checks++;
      if (chan(3) !== e) begin errors++; $display("FAIL period0[%0d]: got %b want %b", k, chan(3), e); end
    end
  endtask
  task automatic test_reset_mid;
    logic [4:0] e;
    start = 4'b1111;
    repeat (3) begin @(negedge clk); start = '0; end
    checks++; if (busy !== 4'b1111) begin errors++; $display("FAIL mid_busy_before: got %b want 1111", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({out, tick, done, busy, cfg_pend} !== 20'b0) begin errors++; $display("FAIL mid_reset: got %b want all zero", {out, tick, done, busy, cfg_pend}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({out, busy} !== 8'b0) begin errors++; $display("FAIL no_restart: got %b want 00000000", {out, busy}); end
    start = 4'b0001;
    repeat (4) sb.push_back(5'b00100);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); start = '0;
      e = sb.pop_front(); checks++;
      if (chan(0) !== e) begin errors++; $display("FAIL cfg_cleared[%0d]: got %b want %b", k, chan(0), e); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_cfg_update;
    test_delay_reps;
    test_start_stop;
    test_edges;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
